fht_frame_sched: RTL and testbench

//  Frame-level sequencer around the 4-bank FHT core. Accepts a stream of N = 4<<A_BIT samples, writes them into

---
 rtl/fht_frame_sched_pkg.sv | 24 ++
 rtl/fht_frame_sched_out_skid.sv | 71 +++++++
 rtl/fht_frame_sched.sv | 172 +++++++++++++++++
 tb/tb_fht_frame_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fht_frame_sched_pkg.sv
// Shared definitions for the FHT frame scheduler: state encodings and bank geometry.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package fht_frame_sched_pkg;

  localparam int BANKS      = 4;
  localparam int BANK_SEL_W = 2;

  typedef enum logic [2:0] {
    FS_IDLE   = 3'd0,
    FS_LOAD   = 3'd1,
    FS_START  = 3'd2,
    FS_ARM    = 3'd3,
    FS_RUN    = 3'd4,
    FS_UNLOAD = 3'd5
  } fs_state_t;

  // One-hot bank write enable from a bank select
  function automatic logic [BANKS-1:0] bank_onehot(input logic [BANK_SEL_W-1:0] sel);
    bank_onehot      = '0;
    bank_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/fht_frame_sched_out_skid.sv
// 2-entry result FIFO absorbing the one-cycle bank RAM read latency.
// Latency: a pushed entry is visible at the output the cycle after the push.
// Backpressure: output held stable while iRDY=0; the producer guarantees it never pushes into a full FIFO.
module fht_frame_sched_out_skid #(
  parameter int W = 17
) (
  input  logic         iCLK,
  input  logic         iRESET,
  input  logic         iCLR,
  input  logic         iPUSH,
  input  logic [W-1:0] iPUSH_DAT,
  output logic         oVLD,
  output logic [W-1:0] oDAT,
  input  logic         iRDY,
  output logic [1:0]   oCNT
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  assign oVLD = (cnt_q != 2'd0);
  assign oDAT = e0_q;
  assign oCNT = cnt_q;

  // Next-state: entry 0 is always the head; entry 1 shifts down on pop
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    pop   = oVLD & iRDY;
    if (iCLR) begin
      cnt_d = 2'd0;
    end else begin
      case ({iPUSH, pop})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = iPUSH_DAT;
          end else begin
            e0_d = e1_q;
            e1_d = iPUSH_DAT;
          end
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = iPUSH_DAT;
          else               e1_d = iPUSH_DAT;
          cnt_d = cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // FIFO storage and occupancy registers
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fht_frame_sched.sv
// Frame sequencer around the 4-bank FHT: bit-reversed load into pair A, start/wait, natural-order unload.
// Latency: load writes are combinational with the input handshake; first result 2 cycles after UNLOAD entry.
// Backpressure: oIN_READY only in LOAD; unload reads throttled so the 2-entry result FIFO never overflows.
module fht_frame_sched #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iFLUSH,
  input  logic             iIN_VALID,
  input  logic [D_BIT-1:0] iIN_DATA,
  output logic             oIN_READY,
  output logic [3:0]       oLD_WE,
  output logic [A_BIT-1:0] oLD_ADDR,
  output logic [D_BIT-1:0] oLD_DATA,
  output logic             oFHT_START,
  input  logic             iFHT_RDY,
  input  logic             iFHT_SOURCE,
  output logic             oRD_PAIR,
  output logic [1:0]       oRD_BANK,
  output logic [A_BIT-1:0] oRD_ADDR,
  input  logic [D_BIT-1:0] iRD_DATA,
  output logic             oOUT_VALID,
  output logic [D_BIT-1:0] oOUT_DATA,
  output logic             oOUT_LAST,
  input  logic             iOUT_READY,
  output logic             oBUSY
);
  import fht_frame_sched_pkg::*;

  localparam int NB = A_BIT + 2;
  // N-1 is all ones in NB bits
  localparam logic [NB-1:0] LAST_IDX = '1;

  function automatic logic [NB-1:0] bitrev(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) bitrev[i] = v[NB-1-i];
  endfunction

  fs_state_t     state_q, state_d;
  logic [NB-1:0] n_q, n_d, k_q, k_d;
  logic          rd_done_q, rd_done_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic          rd_pair_q, rd_pair_d;
  logic [NB-1:0] rev;
  logic [1:0]    fifo_cnt;
  logic [2:0]    occ;
  logic          issue, pop, fifo_vld;
  logic [D_BIT:0] fifo_dat;

  assign oRD_PAIR   = rd_pair_q;
  assign oRD_BANK   = k_q[1:0];
  assign oRD_ADDR   = k_q[NB-1:2];
  assign oOUT_VALID = fifo_vld;
  assign oOUT_DATA  = fifo_dat[D_BIT-1:0];
  assign oOUT_LAST  = fifo_dat[D_BIT];
  assign oBUSY      = (state_q != FS_IDLE);

  // Next-state, counters and per-state outputs; flush overrides everything
  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    k_d             = k_q;
    rd_done_d       = rd_done_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    rd_pair_d       = rd_pair_q;
    oIN_READY       = 1'b0;
    oLD_WE          = '0;
    oLD_ADDR        = '0;
    oLD_DATA        = '0;
    oFHT_START      = 1'b0;
    issue           = 1'b0;
    rev             = bitrev(n_q);
    pop             = fifo_vld & iOUT_READY;
    // Slots committed after this cycle: entries kept plus the read already in flight
    occ             = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    case (state_q)
      FS_IDLE: begin
        if (iIN_VALID) state_d = FS_LOAD;
      end
      FS_LOAD: begin
        oIN_READY = 1'b1;
        if (iIN_VALID) begin
          oLD_WE   = bank_onehot(rev[1:0]);
          oLD_ADDR = rev[NB-1:2];
          oLD_DATA = iIN_DATA;
          if (n_q == LAST_IDX) begin
            n_d     = '0;
            state_d = FS_START;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      FS_START: begin
        oFHT_START = 1'b1;
        state_d    = FS_ARM;
      end
      FS_ARM: begin
        if (!iFHT_RDY) state_d = FS_RUN;
      end
      FS_RUN: begin
        if (iFHT_RDY) begin
          state_d   = FS_UNLOAD;
          rd_pair_d = iFHT_SOURCE;
        end
      end
      FS_UNLOAD: begin
        issue           = !rd_done_q && (occ < 3'd2);
        inflight_d      = issue;
        inflight_last_d = issue && (k_q == LAST_IDX);
        if (issue) begin
          if (k_q == LAST_IDX) begin
            k_d       = '0;
            rd_done_d = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        if (pop && fifo_dat[D_BIT]) begin
          state_d   = FS_IDLE;
          rd_done_d = 1'b0;
        end
      end
      default: state_d = FS_IDLE;
    endcase
    if (iFLUSH) begin
      state_d         = FS_IDLE;
      n_d             = '0;
      k_d             = '0;
      rd_done_d       = 1'b0;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
    end
  end

  // State, counters and read-pipeline tracking registers
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q         <= FS_IDLE;
      n_q             <= '0;
      k_q             <= '0;
      rd_done_q       <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_pair_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      k_q             <= k_d;
      rd_done_q       <= rd_done_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      rd_pair_q       <= rd_pair_d;
    end
  end

  fht_frame_sched_out_skid #(.W(D_BIT + 1)) u_skid (
    .iCLK      (iCLK),
    .iRESET    (iRESET),
    .iCLR      (iFLUSH),
    .iPUSH     (inflight_q),
    .iPUSH_DAT ({inflight_last_q, iRD_DATA}),
    .oVLD      (fifo_vld),
    .oDAT      (fifo_dat),
    .iRDY      (iOUT_READY),
    .oCNT      (fifo_cnt)
  );

endmodule

// File: tb/tb_fht_frame_sched.sv
// Scoreboard bench for fht_frame_sched at A_BIT=2 (N=16) with a bank RAM and FHT controller model.
// Latency: checks start pulse timing, first-result latency and full-rate unload.
// Backpressure: exercises ready held high and ready toggling every cycle.
module tb_fht_frame_sched;
  localparam int A_BIT = 2;
  localparam int D_BIT = 16;
  localparam int N     = 16;

  logic        iCLK = 1'b0, iRESET = 1'b0, iFLUSH = 1'b0;
  logic        iIN_VALID = 1'b0, iFHT_RDY = 1'b1, iFHT_SOURCE = 1'b0, iOUT_READY = 1'b1;
  logic [15:0] iIN_DATA = '0, iRD_DATA = '0;
  logic        oIN_READY, oFHT_START, oRD_PAIR, oOUT_VALID, oOUT_LAST, oBUSY;
  logic [3:0]  oLD_WE;
  logic [1:0]  oLD_ADDR, oRD_BANK, oRD_ADDR;
  logic [15:0] oLD_DATA, oOUT_DATA;

  fht_frame_sched #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iFLUSH(iFLUSH),
    .iIN_VALID(iIN_VALID), .iIN_DATA(iIN_DATA), .oIN_READY(oIN_READY),
    .oLD_WE(oLD_WE), .oLD_ADDR(oLD_ADDR), .oLD_DATA(oLD_DATA),
    .oFHT_START(oFHT_START), .iFHT_RDY(iFHT_RDY), .iFHT_SOURCE(iFHT_SOURCE),
    .oRD_PAIR(oRD_PAIR), .oRD_BANK(oRD_BANK), .oRD_ADDR(oRD_ADDR), .iRD_DATA(iRD_DATA),
    .oOUT_VALID(oOUT_VALID), .oOUT_DATA(oOUT_DATA), .oOUT_LAST(oOUT_LAST),
    .iOUT_READY(iOUT_READY), .oBUSY(oBUSY)
  );

  initial forever #5 iCLK = ~iCLK;

  typedef struct packed {logic [3:0] we; logic [1:0] addr; logic [15:0] dat;} ld_t;
  typedef struct packed {logic last; logic [15:0] dat;} out_t;

  ld_t  ld_q[$];
  out_t exp_q[$];
  int   total = 0, bad = 0;
  int   rdy_mode = 0;
  logic [15:0] ramA [4][4];
  logic [15:0] ramB [4][4];
  logic [15:0] xs [16];
  // Hand-computed 4-bit bit reversal: linear RAM position of sample n
  int rev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Load-path monitor: every bank write must match the next expected write; also fills pair A
  initial begin : ld_mon
    ld_t l;
    forever begin
      @(negedge iCLK); #3;
      if (iRESET && oLD_WE != 4'b0) begin
        if (ld_q.size() == 0) chk("ld_spurious", {28'b0, oLD_WE}, 0);
        else begin
          l = ld_q.pop_front();
          chk("ld_we", {28'b0, oLD_WE}, {28'b0, l.we});
          chk("ld_addr", {30'b0, oLD_ADDR}, {30'b0, l.addr});
          chk("ld_data", {16'b0, oLD_DATA}, {16'b0, l.dat});
        end
        for (int i = 0; i < 4; i++) if (oLD_WE[i]) ramA[i][oLD_ADDR] = oLD_DATA;
      end
    end
  end

  // Bank RAM read model: address sampled in one cycle, data presented the next
  logic       rp = 1'b0;
  logic [1:0] rb = '0, ra = '0;
  initial forever begin
    @(negedge iCLK); #3;
    rp = oRD_PAIR; rb = oRD_BANK; ra = oRD_ADDR;
  end
  initial forever begin
    @(posedge iCLK); #1;
    iRD_DATA = rp ? ramB[rb][ra] : ramA[rb][ra];
  end

  // Sink ready: constant 1 or toggling every cycle
  initial forever begin
    @(posedge iCLK); #1;
    iOUT_READY = (rdy_mode == 0) ? 1'b1 : ~iOUT_READY;
  end

  // Result monitor: pops the scoreboard on each handshake, checks hold while stalled
  initial begin : out_mon
    logic stall;
    out_t held, e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge iCLK); #3;
      if (!iRESET) stall = 1'b0;
      else begin
        if (stall) begin
          chk("out_hold_vld", {31'b0, oOUT_VALID}, 1);
          chk("out_hold_dat", {15'b0, oOUT_LAST, oOUT_DATA}, {15'b0, held});
        end
        if (oOUT_VALID && iOUT_READY) begin
          if (exp_q.size() == 0) chk("out_spurious", {31'b0, oOUT_VALID}, 0);
          else begin
            e = exp_q.pop_front();
            chk("out_data", {16'b0, oOUT_DATA}, {16'b0, e.dat});
            chk("out_last", {31'b0, oOUT_LAST}, {31'b0, e.last});
          end
        end
        stall = oOUT_VALID && !iOUT_READY;
        held  = {oOUT_LAST, oOUT_DATA};
      end
    end
  end

  // abort: 0 none, 1 flush during RUN, 2 reset mid-unload
  task automatic run_frame(input int f, input int gap, input bit src, input int mode, input int abort);
    int   c;
    ld_t  l;
    out_t e;
    rdy_mode = mode;
    for (int n = 0; n < N; n++) begin
      xs[n]  = 16'(f * 4099 + n * 257 + 3);
      l.we   = 4'b0001 << (rev_tab[n] % 4);
      l.addr = 2'(rev_tab[n] / 4);
      l.dat  = xs[n];
      ld_q.push_back(l);
    end
    if (abort != 1)
      for (int k = 0; k < N; k++) begin
        e.dat  = src ? (xs[rev_tab[k]] ^ 16'h5A5A) : xs[rev_tab[k]];
        e.last = (k == N - 1);
        exp_q.push_back(e);
      end
    for (int n = 0; n < N; n++) begin
      @(negedge iCLK);
      iIN_VALID = 1'b1;
      iIN_DATA  = xs[n];
      if (n == 0) chk("idle_not_ready", {31'b0, oIN_READY}, 0);
      c = 0;
      while (!oIN_READY && c < 5) begin @(negedge iCLK); c++; end
      if (c >= 5) chk("load_ready_timeout", {31'b0, oIN_READY}, 1);
      if (n != N - 1)
        for (int g = 1; g < gap; g++) begin @(negedge iCLK); iIN_VALID = 1'b0; end
    end
    @(negedge iCLK);
    iIN_VALID = 1'b0;
    chk("start_pulse", {31'b0, oFHT_START}, 1);
    @(negedge iCLK);
    chk("start_width", {31'b0, oFHT_START}, 0);
    chk("arm_busy", {31'b0, oBUSY}, 1);
    repeat (2) @(negedge iCLK);
    iFHT_RDY = 1'b0;
    chk("ld_all_written", ld_q.size(), 0);
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 4; a++) ramB[b][a] = ramA[b][a] ^ 16'h5A5A;
    repeat (10) @(negedge iCLK);
    if (abort == 1) begin
      iFLUSH = 1'b1;
      @(negedge iCLK);
      iFLUSH = 1'b0;
      chk("flush_busy", {31'b0, oBUSY}, 0);
    end
    repeat (30) @(negedge iCLK);
    iFHT_SOURCE = src;
    iFHT_RDY    = 1'b1;
    if (abort == 1) begin
      repeat (10) @(negedge iCLK);
      chk("flush_idle", {31'b0, oBUSY}, 0);
      chk("flush_no_out", {31'b0, oOUT_VALID}, 0);
      return;
    end
    c = 0;
    do begin
      @(negedge iCLK);
      c++;
      if (c == 1) chk("rd_pair", {31'b0, oRD_PAIR}, {31'b0, src});
    end while (!oOUT_VALID && c < 10);
    chk("first_out_lat", c, 3);
    if (abort == 2) begin
      c = 0;
      while (exp_q.size() > 10 && c < 100) begin @(negedge iCLK); c++; end
      @(posedge iCLK); #2;
      iRESET = 1'b0;
      exp_q.delete();
      @(negedge iCLK);
      chk("rst_busy", {31'b0, oBUSY}, 0);
      chk("rst_no_out", {31'b0, oOUT_VALID}, 0);
      chk("rst_rd_pair", {31'b0, oRD_PAIR}, 0);
      @(negedge iCLK);
      iRESET = 1'b1;
      repeat (5) @(negedge iCLK);
      chk("rst_still_idle", {31'b0, oOUT_VALID | oBUSY}, 0);
      return;
    end
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin @(negedge iCLK); c++; end
    chk("drained", exp_q.size(), 0);
    if (mode == 0) chk("full_rate", c, 16);
    repeat (2) @(negedge iCLK);
    chk("end_busy", {31'b0, oBUSY}, 0);
    chk("end_no_out", {31'b0, oOUT_VALID}, 0);
  endtask

  initial begin
    repeat (2) @(negedge iCLK);
    chk("rst_busy0", {31'b0, oBUSY}, 0);
    chk("rst_in_ready0", {31'b0, oIN_READY}, 0);
    chk("rst_out_valid0", {31'b0, oOUT_VALID}, 0);
    chk("rst_start0", {31'b0, oFHT_START}, 0);
    chk("rst_ld_we0", {28'b0, oLD_WE}, 0);
    chk("rst_rd_pair0", {31'b0, oRD_PAIR}, 0);
    iRESET = 1'b1;
    run_frame(1, 1, 1'b1, 0, 0);
    run_frame(2, 3, 1'b1, 1, 0);
    run_frame(3, 1, 1'b0, 0, 1);
    run_frame(4, 2, 1'b0, 0, 0);
    run_frame(5, 1, 1'b1, 0, 2);
    run_frame(6, 1, 1'b0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
